// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the single register-file write-back port.
// Grants one of ALU / load / link results per cycle and registers the winning write.
module wb_port_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int RD_W      = 5,
  parameter int MAX_STALL = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         req_valid,
  input  logic [RD_W-1:0]    req_rd0,
  input  logic [RD_W-1:0]    req_rd1,
  input  logic [RD_W-1:0]    req_rd2,
  output logic [2:0]         req_ready,
  input  logic               wb_stall,
  output logic               wb_valid,
  output logic               wb_we,
  output logic [RD_W-1:0]    wb_rd,
  output logic [2:0]         wb_sel,
  output logic               stall_err
);

  localparam int CNT_W = $clog2(MAX_STALL + 1);

  logic [1:0]       ptr_reg;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic             wb_valid_reg;
  logic             wb_we_reg;
  logic [RD_W-1:0]  wb_rd_reg;
  logic [2:0]       wb_sel_reg;
  logic             stall_err_reg;

  logic [RD_W-1:0]    rd_arr   [NUM_REQ];
  logic [1:0]         cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_hit;
  logic [1:0]         winner;
  logic [2:0]         winner_sel;
  logic               stalled;
  logic               accept;

  assign rd_arr[0] = req_rd0;
  assign rd_arr[1] = req_rd1;
  assign rd_arr[2] = req_rd2;

  // Candidate gi is the requester sitting gi places after the pointer (mod 3).
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [2:0] sum;
      assign sum          = {1'b0, ptr_reg} + 3'(gi);
      assign cand_idx[gi] = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      assign cand_hit[gi] = req_valid[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    winner = cand_idx[0];
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) winner = cand_idx[k];
    end
  end

  assign stalled    = wb_valid_reg && wb_stall;
  assign accept     = !rst && !stalled && (|req_valid);
  assign winner_sel = {winner == 2'd2, winner == 2'd1, 1'b1};

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = accept && (winner == 2'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg      <= 2'd0;
      wb_valid_reg <= 1'b0;
      wb_we_reg    <= 1'b0;
      wb_rd_reg    <= '0;
      wb_sel_reg   <= 3'b000;
    end else if (accept) begin
      ptr_reg      <= (winner == 2'd2) ? 2'd0 : winner + 2'd1;
      wb_valid_reg <= 1'b1;
      wb_we_reg    <= (rd_arr[winner] != '0);
      wb_rd_reg    <= rd_arr[winner];
      wb_sel_reg   <= winner_sel;
    end else if (!stalled) begin
      // Idle drains the stage but leaves wb_rd at its last value.
      wb_valid_reg <= 1'b0;
      wb_we_reg    <= 1'b0;
      wb_sel_reg   <= 3'b000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      stall_err_reg <= 1'b0;
    end else if (stalled) begin
      if (stall_cnt_reg != CNT_W'(MAX_STALL)) stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (stall_cnt_reg >= CNT_W'(MAX_STALL - 1)) stall_err_reg <= 1'b1;
    end else begin
      stall_cnt_reg <= '0;
    end
  end

  assign wb_valid  = wb_valid_reg;
  assign wb_we     = wb_we_reg;
  assign wb_rd     = wb_rd_reg;
  assign wb_sel    = wb_sel_reg;
  assign stall_err = stall_err_reg;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: per-cycle comparison against a behavioural model
// plus directed literal checks of reset, round-robin order, x0 writes and stalls.
module tb_wb_port_arbiter;

  localparam int RD_W = 5;
  localparam int MAXS = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      req_valid;
  logic [RD_W-1:0] req_rd0, req_rd1, req_rd2;
  logic [2:0]      req_ready;
  logic            wb_stall;
  logic            wb_valid, wb_we, stall_err;
  logic [RD_W-1:0] wb_rd;
  logic [2:0]      wb_sel;

  wb_port_arbiter #(.NUM_REQ(3), .RD_W(RD_W), .MAX_STALL(MAXS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .req_rd0(req_rd0), .req_rd1(req_rd1), .req_rd2(req_rd2),
    .req_ready(req_ready), .wb_stall(wb_stall),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_sel(wb_sel), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit run_cmp  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pointer, one-entry output stage, stall count
  int m_ptr = 0, m_cnt = 0;
  bit m_valid = 0, m_we = 0, m_err = 0;
  int m_rd = 0, m_sel = 0;

  function automatic int sel_code(input int r);
    int codes[3] = '{1, 3, 5};
    return codes[r];
  endfunction

  function automatic int pick();
    int i;
    if (rst || (m_valid && wb_stall)) return -1;
    for (int k = 0; k < 3; k++) begin
      i = (m_ptr + k) % 3;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic int rd_of(input int r);
    if (r == 0) return int'(req_rd0);
    if (r == 1) return int'(req_rd1);
    return int'(req_rd2);
  endfunction

  always @(posedge clk) begin
    int g;
    bit st;
    if (rst) begin
      m_ptr = 0; m_cnt = 0; m_valid = 0; m_we = 0; m_err = 0; m_rd = 0; m_sel = 0;
    end else begin
      g  = pick();
      st = m_valid && wb_stall;
      if (st) begin
        m_cnt = (m_cnt + 1 > MAXS) ? MAXS : m_cnt + 1;
        if (m_cnt == MAXS) m_err = 1;
      end else m_cnt = 0;
      if (g >= 0) begin
        m_valid = 1; m_rd = rd_of(g); m_we = (m_rd != 0); m_sel = sel_code(g);
        m_ptr = (g + 1) % 3;
      end else if (!st) begin
        m_valid = 0; m_we = 0; m_sel = 0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    if (run_cmp) begin
      g = pick();
      chk("cmp_req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
      chk("cmp_wb_valid",  32'(wb_valid),  32'(m_valid));
      chk("cmp_wb_we",     32'(wb_we),     32'(m_we));
      chk("cmp_wb_rd",     32'(wb_rd),     32'(m_rd));
      chk("cmp_wb_sel",    32'(wb_sel),    32'(m_sel));
      chk("cmp_stall_err", 32'(stall_err), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] v, input int r0, input int r1, input int r2, input logic st);
    req_valid = v;
    req_rd0 = RD_W'(r0); req_rd1 = RD_W'(r1); req_rd2 = RD_W'(r2);
    wb_stall = st;
  endtask

  logic [2:0] rr_sel [3] = '{3'b001, 3'b011, 3'b101};
  logic [3:0] mix_tab [8] = '{4'b1110, 4'b0110, 4'b1011, 4'b1000, 4'b0101, 4'b0111, 4'b0000, 4'b1010};

  initial begin
    // Reset with all requesters asserted
    rst = 1'b1;
    drive(3'b111, 1, 2, 3, 1'b0);
    #1 chk("reset_ready", 32'(req_ready), 32'd0);
    tick();
    run_cmp = 1;
    tick();
    chk("reset_ready2", 32'(req_ready), 32'd0);
    rst = 1'b0;
    drive(3'b000, 0, 0, 0, 1'b0);
    tick();
    chk("reset_wb_valid", 32'(wb_valid), 32'd0);
    chk("reset_wb_sel", 32'(wb_sel), 32'd0);
    chk("reset_stall_err", 32'(stall_err), 32'd0);

    // Single request from requester 1
    drive(3'b010, 0, 7, 0, 1'b0);
    #1 chk("single_ready", 32'(req_ready), 32'b010);
    tick();
    drive(3'b000, 0, 0, 0, 1'b0);
    chk("single_valid", 32'(wb_valid), 32'd1);
    chk("single_we", 32'(wb_we), 32'd1);
    chk("single_rd", 32'(wb_rd), 32'd7);
    chk("single_sel", 32'(wb_sel), 32'b011);
    tick();

    // Round robin from a fresh pointer
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      drive((k < 6) ? 3'b111 : 3'b000, 1, 2, 3, 1'b0);
      if (k > 0) begin
        chk("rr_sel", 32'(wb_sel), 32'(rr_sel[(k - 1) % 3]));
        chk("rr_rd", 32'(wb_rd), 32'((k - 1) % 3 + 1));
      end
      #1;
      if (k < 6) chk("rr_ready", 32'(req_ready), 32'd1 << (k % 3));
      tick();
    end

    // Write to x0 from requester 2 (pointer wrapped back to 0)
    drive(3'b100, 0, 0, 0, 1'b0);
    tick();
    drive(3'b000, 0, 0, 0, 1'b0);
    chk("x0_valid", 32'(wb_valid), 32'd1);
    chk("x0_we", 32'(wb_we), 32'd0);
    chk("x0_sel", 32'(wb_sel), 32'b101);
    tick();

    // Stall holds a write to rd=5
    drive(3'b001, 5, 0, 0, 1'b0);
    tick();
    for (int s = 0; s < 3; s++) begin
      drive(3'b001, 9, 0, 0, 1'b1);
      #1 chk("stall_ready", 32'(req_ready), 32'd0);
      tick();
      chk("stall_rd", 32'(wb_rd), 32'd5);
      chk("stall_sel", 32'(wb_sel), 32'b001);
      chk("stall_valid", 32'(wb_valid), 32'd1);
    end
    drive(3'b001, 9, 0, 0, 1'b0);
    #1 chk("release_ready", 32'(req_ready), 32'b001);
    tick();
    chk("release_rd", 32'(wb_rd), 32'd9);
    chk("short_stall_err", 32'(stall_err), 32'd0);

    // Stall long enough to set the sticky error
    for (int s = 0; s < 4; s++) begin
      drive(3'b000, 0, 0, 0, 1'b1);
      tick();
      if (s == 2) chk("err_before", 32'(stall_err), 32'd0);
      if (s == 3) chk("err_set", 32'(stall_err), 32'd1);
    end
    drive(3'b000, 0, 0, 0, 1'b0);
    tick(); tick();
    chk("err_sticky", 32'(stall_err), 32'd1);

    // Mixed request/stall patterns, checked by the per-cycle model
    for (int k = 0; k < 8; k++) begin
      drive(mix_tab[k][3:1], k + 1, 0, 30 - k, mix_tab[k][0]);
      tick();
    end

    rst = 1'b1; tick(); rst = 1'b0;
    drive(3'b000, 0, 0, 0, 1'b0);
    tick();
    chk("err_cleared", 32'(stall_err), 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
